// File: rtl/mem_bus_if.sv
// mem_bus_if: rd/wr strobe bus between the CPU controller (master) and a memory responder (slave).
interface mem_bus_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  rd;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_vld;
  logic                  wr_ack;
  logic                  busy;
  logic                  err;
  modport master (output rd, wr, addr, wdata, input rdata, rdata_vld, wr_ack, busy, err);
  modport slave  (input rd, wr, addr, wdata, output rdata, rdata_vld, wr_ack, busy, err);
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte RAM behind an rd/wr strobe bus with programmable read wait states.
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_AW      = 8,
  parameter int WAIT_STATES = 1
) (
  input logic      clk,
  input logic      rst,
  mem_bus_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RWAIT, RDATA, WCOMMIT} state_t;
  state_t                state;
  logic                  rd_q, wr_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic [2:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic rd_start, wr_start, conflict, addr_ok, aq_ok, we;
  assign rd_start = bus.rd & ~rd_q;
  assign wr_start = bus.wr & ~wr_q;
  assign conflict = bus.rd & bus.wr;
  assign addr_ok  = bus.addr[ADDR_WIDTH-1:MEM_AW] == '0;
  assign aq_ok    = a_q[ADDR_WIDTH-1:MEM_AW] == '0;
  assign we       = !rst && !conflict && state == WCOMMIT && aq_ok;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    if (we) mem[a_q[MEM_AW-1:0]] <= d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      bus.rdata     <= '0;
      bus.rdata_vld <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      rd_q       <= bus.rd;
      wr_q       <= bus.wr;
      bus.wr_ack <= 1'b0;
      bus.err    <= 1'b0;
      if (conflict) begin
        bus.err       <= 1'b1;
        bus.rdata_vld <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE:
            if (rd_start) begin
              a_q <= bus.addr;
              cnt <= 3'(WAIT_STATES);
              if (WAIT_STATES == 0) begin
                bus.rdata     <= addr_ok ? mem[bus.addr[MEM_AW-1:0]] : '0;
                bus.rdata_vld <= 1'b1;
                bus.err       <= !addr_ok;
                state         <= RDATA;
              end else
                state <= RWAIT;
            end else if (wr_start) begin
              a_q   <= bus.addr;
              d_q   <= bus.wdata;
              state <= WCOMMIT;
            end
          RWAIT:
            if (!bus.rd) begin
              bus.err <= wr_start;
              state   <= IDLE;
            end else if (cnt == 3'd1) begin
              bus.rdata     <= aq_ok ? mem[a_q[MEM_AW-1:0]] : '0;
              bus.rdata_vld <= 1'b1;
              bus.err       <= !aq_ok;
              state         <= RDATA;
            end else
              cnt <= cnt - 3'd1;
          RDATA:
            if (!bus.rd) begin
              bus.rdata_vld <= 1'b0;
              bus.err       <= wr_start;
              state         <= IDLE;
            end
          WCOMMIT: begin
            bus.wr_ack <= 1'b1;
            bus.err    <= !aq_ok;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of a W=1 and a W=3 responder driven by the same bus stimulus.
module tb_mem_bus_responder;
  logic clk = 1'b0, rst = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  mem_bus_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) b1 ();
  mem_bus_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8)) b3 ();
  assign b1.rd = rd;
  assign b1.wr = wr;
  assign b1.addr = addr;
  assign b1.wdata = wdata;
  assign b3.rd = rd;
  assign b3.wr = wr;
  assign b3.addr = addr;
  assign b3.wdata = wdata;
  mem_bus_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .MEM_AW(8), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_bus_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .MEM_AW(8), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick(); tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [12:0] a, output logic [7:0] d, output logic v);
    addr = a; rd = 1'b1;
    tick(); tick();
    d = b1.rdata; v = b1.rdata_vld;
    rd = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (b1.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", b1.rdata); end
    checks++; if ({b1.rdata_vld, b1.wr_ack, b1.busy, b1.err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {b1.rdata_vld, b1.wr_ack, b1.busy, b1.err}); end
  endtask

  task automatic test_write_read();
    addr = 13'h0012; wdata = 8'hA5; wr = 1'b1;
    tick();
    checks++; if ({b1.wr_ack, b1.busy} !== 2'b01) begin errors++; $display("FAIL wr_e1 ack/busy got %b exp 01", {b1.wr_ack, b1.busy}); end
    tick();
    checks++; if ({b1.wr_ack, b1.err} !== 2'b10) begin errors++; $display("FAIL wr_e2 ack/err got %b exp 10", {b1.wr_ack, b1.err}); end
    wr = 1'b0;
    tick();
    checks++; if ({b1.wr_ack, b1.busy} !== 2'b00) begin errors++; $display("FAIL wr_e3 ack/busy got %b exp 00", {b1.wr_ack, b1.busy}); end
    rd = 1'b1;
    tick();
    checks++; if (b1.rdata_vld !== 1'b0) begin errors++; $display("FAIL rd_w1_e1 vld got %b exp 0", b1.rdata_vld); end
    tick();
    checks++; if ({b1.rdata_vld, b1.rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_w1_e2 vld/data got %b/%h exp 1/a5", b1.rdata_vld, b1.rdata); end
    tick();
    checks++; if ({b1.rdata_vld, b1.rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL rd_w1_hold got %b/%h exp 1/a5", b1.rdata_vld, b1.rdata); end
    rd = 1'b0;
    tick();
    checks++; if ({b1.rdata_vld, b1.busy, b1.rdata} !== {2'b00, 8'hA5}) begin errors++; $display("FAIL rd_w1_drop got %b%b/%h exp 00/a5", b1.rdata_vld, b1.busy, b1.rdata); end
  endtask

  task automatic test_wait3();
    addr = 13'h0012; rd = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++; if (b3.rdata_vld !== (e >= 4)) begin errors++; $display("FAIL rd_w3_edge%0d vld got %b exp %b", e, b3.rdata_vld, e >= 4); end
    end
    checks++; if (b3.rdata !== 8'hA5) begin errors++; $display("FAIL rd_w3_data got %h exp a5", b3.rdata); end
    rd = 1'b0;
    tick();
    rd = 1'b1;
    tick(); tick();
    rd = 1'b0;
    tick();
    checks++; if ({b3.rdata_vld, b3.busy} !== 2'b00) begin errors++; $display("FAIL rd_w3_abort vld/busy got %b exp 00", {b3.rdata_vld, b3.busy}); end
    tick(); tick();
    checks++; if (b3.rdata_vld !== 1'b0) begin errors++; $display("FAIL rd_w3_abort_late vld got %b exp 0", b3.rdata_vld); end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    logic v;
    addr = 13'h0012; wdata = 8'h77; rd = 1'b1;
    tick();
    checks++; if (b1.busy !== 1'b1) begin errors++; $display("FAIL conf_rwait busy got %b exp 1", b1.busy); end
    wr = 1'b1;
    tick();
    checks++; if ({b1.err, b1.busy, b1.rdata_vld} !== 3'b100) begin errors++; $display("FAIL conf_err err/busy/vld got %b exp 100", {b1.err, b1.busy, b1.rdata_vld}); end
    rd = 1'b0; wr = 1'b0;
    tick();
    checks++; if ({b1.err, b1.wr_ack} !== 2'b00) begin errors++; $display("FAIL conf_after err/ack got %b exp 00", {b1.err, b1.wr_ack}); end
    do_read(13'h0012, d, v);
    checks++; if ({v, d} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL conf_reread got %b/%h exp 1/a5", v, d); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    logic v;
    do_write(13'h0000, 8'h11);
    addr = 13'h0100; wdata = 8'h5A; wr = 1'b1;
    tick();
    checks++; if ({b1.err, b1.wr_ack} !== 2'b00) begin errors++; $display("FAIL oor_wr_e1 err/ack got %b exp 00", {b1.err, b1.wr_ack}); end
    tick();
    checks++; if ({b1.err, b1.wr_ack} !== 2'b11) begin errors++; $display("FAIL oor_wr_e2 err/ack got %b exp 11", {b1.err, b1.wr_ack}); end
    wr = 1'b0;
    tick();
    checks++; if (b1.err !== 1'b0) begin errors++; $display("FAIL oor_wr_e3 err got %b exp 0", b1.err); end
    rd = 1'b1;
    tick(); tick();
    checks++; if ({b1.rdata_vld, b1.err, b1.rdata} !== {2'b11, 8'h00}) begin errors++; $display("FAIL oor_rd vld/err/data got %b%b/%h exp 11/00", b1.rdata_vld, b1.err, b1.rdata); end
    tick();
    checks++; if ({b1.rdata_vld, b1.err} !== 2'b10) begin errors++; $display("FAIL oor_rd_next vld/err got %b exp 10", {b1.rdata_vld, b1.err}); end
    rd = 1'b0;
    tick();
    do_read(13'h0000, d, v);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL oor_no_alias got %h exp 11", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic v;
    int acks;
    addr = 13'h00FF; wdata = 8'h3C; wr = 1'b1;
    tick(); tick();
    checks++; if (b1.wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", b1.wr_ack); end
    wr = 1'b0;
    tick();
    wdata = 8'hC3; wr = 1'b1;
    tick(); tick();
    checks++; if (b1.wr_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b exp 1", b1.wr_ack); end
    wr = 1'b0;
    tick();
    do_read(13'h00FF, d, v);
    checks++; if ({v, d} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL b2b_read got %b/%h exp 1/c3", v, d); end
    acks = 0;
    addr = 13'h0020; wdata = 8'h99; wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(b1.wr_ack);
    end
    wr = 1'b0;
    tick(); acks += int'(b1.wr_ack);
    tick(); acks += int'(b1.wr_ack);
    checks++; if (acks !== 1) begin errors++; $display("FAIL held_wr_acks got %0d exp 1", acks); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    logic v;
    addr = 13'h00FF; wdata = 8'h55; wr = 1'b1;
    tick();
    rst = 1'b1; wr = 1'b0;
    tick();
    checks++; if ({b1.wr_ack, b1.busy} !== 2'b00) begin errors++; $display("FAIL rst_wr ack/busy got %b exp 00", {b1.wr_ack, b1.busy}); end
    rst = 1'b0;
    tick();
    do_read(13'h00FF, d, v);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rst_wr_ram got %h exp c3", d); end
    rd = 1'b1;
    tick(); tick();
    checks++; if ({b1.rdata_vld, b1.rdata} !== {1'b1, 8'hC3}) begin errors++; $display("FAIL rst_rd_pre got %b/%h exp 1/c3", b1.rdata_vld, b1.rdata); end
    rst = 1'b1;
    tick();
    checks++; if ({b1.rdata_vld, b1.rdata} !== {1'b0, 8'h00}) begin errors++; $display("FAIL rst_rd got %b/%h exp 0/00", b1.rdata_vld, b1.rdata); end
    rst = 1'b0; rd = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait3();
    test_conflict();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU controller's rd/wr strobe bus.
- Owns an internal byte-wide RAM and serves controller reads with a programmable wait-state count.
- Commits controller writes on the rising edge of wr and acknowledges each write.
- Flags protocol violations: rd and wr both high, or an address outside the implemented RAM.

Parameters:
- ADDR_WIDTH, 13, width of the bus address from the controller.
- DATA_WIDTH, 8, data bus width.
- MEM_AW, 8, implemented RAM address bits; depth is 2**MEM_AW.
- WAIT_STATES, 1, extra clocks between read start and valid data; legal range 0..7.

Ports:
- clk  in  1  clock; all logic on the posedge, half a cycle off the controller's negedge.
- rst  in  1  synchronous, active-high reset.
- rd  in  1  read strobe from the controller, level.
- wr  in  1  write strobe from the controller, level.
- addr  in  ADDR_WIDTH  bus address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  registered read data.
- rdata_vld  out  1  rdata is valid for the current read.
- wr_ack  out  1  one-cycle pulse when a write is committed or rejected.
- busy  out  1  high in any state except IDLE.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE.
  - rdata=0, rdata_vld=0, wr_ack=0, busy=0, err=0; rd_q=0, wr_q=0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the access: no pending write is committed and no read data is delivered.
- Edge detect: rd_q and wr_q are registered copies of rd and wr. A start means the strobe is high now and was low last cycle.
- Range check: addr is in range when addr[ADDR_WIDTH-1:MEM_AW]==0.
- Priority, highest first: rst, then rd&wr both high, then the state logic.
- rd&wr both high, in any state:
  - err pulses for 1 cycle.
  - State goes to IDLE and rdata_vld is cleared.
  - No RAM access occurs.
- State IDLE:
  - Read start: latch addr and load the counter with WAIT_STATES.
    - WAIT_STATES=0: load rdata in the same cycle, set rdata_vld, go to RDATA.
    - Otherwise go to RWAIT.
  - Write start: latch addr and wdata, go to WCOMMIT.
- State RWAIT:
  - rd low: abort to IDLE; rdata_vld stays 0.
  - Counter==1: load rdata from the latched address, set rdata_vld, go to RDATA.
  - Otherwise decrement the counter.
- State RDATA:
  - rdata and rdata_vld hold while rd stays high.
  - rd low: rdata_vld is 0 from the next edge, go to IDLE; rdata holds its last value.
- State WCOMMIT (always exactly 1 cycle):
  - In range: write RAM[latched addr] with the latched wdata.
  - wr_ack pulses in both cases, go to IDLE.
- Out-of-range read: rdata=0 when it is loaded, rdata_vld asserts normally, err pulses on the same edge.
- Out-of-range write: RAM is unchanged, wr_ack still pulses, err pulses on the same edge.
- Read latency: the edge that samples the rd start counts as edge 1. rdata_vld rises at edge WAIT_STATES+1 (W=0 gives edge 1, W=2 gives edge 3).
- Write latency: wr_ack rises at edge 2 and lasts 1 cycle.
- A wr start during RWAIT or RDATA (with rd low by then) is ignored and pulses err.
- A held strobe never retriggers: it must go low and high again to start a new access.
- busy=1 in RWAIT, RDATA and WCOMMIT.

Test Plan:
- Reset, then wr pulse with addr=0x0012 and wdata=0xA5 → wr_ack at edge 2; then rd held with W=1 → rdata_vld at edge 2, rdata=0xA5.
- W=3, rd start at addr 0x0012 → rdata_vld low for edges 1-3 and high from edge 4; drop rd at edge 2 of a second read → rdata_vld never rises and busy=0 by the next edge.
- rd and wr high in the same cycle during RWAIT → err pulses 1 cycle, state IDLE, no RAM change (re-read still returns 0xA5).
- Write addr=0x0100 with MEM_AW=8 → err and wr_ack pulse together; read 0x0100 → rdata=0x00, err pulses, rdata_vld=1.
- Back-to-back writes to 0x00FF with data 0x3C then 0xC3, each with wr dropping between them → two wr_ack pulses; read 0x00FF → 0xC3. Hold wr high for 4 cycles → only 1 wr_ack.
- rst asserted the cycle after a write start → no wr_ack, RAM unchanged; rst during RDATA → rdata_vld=0 and rdata=0 on the next edge.
